// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the UART packet decoder.
package uart_pkt_pkg;

    // Decoder framing state
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

    // Completion status reported with pkt_done
    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_SUM     = 2'd1,
        ERR_LEN     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } pkt_err_t;

    // Required value of header bits [15:8]
    localparam logic [7:0] PKT_SYNC = 8'hA5;

endpackage

// File: rtl/uart_pkt_timeout.sv
// Inter-word timeout: down-counter reloaded by clear, decremented by enable.
// expire strobes combinationally in the TIMEOUT_CYC-th consecutive enabled cycle.
module uart_pkt_timeout #(
    parameter int unsigned TIMEOUT_CYC = 112500
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned W = $clog2(TIMEOUT_CYC + 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Reload on clear, count down while enabled, flag the last allowed cycle
    always_comb begin
        count_d = count_q;
        expire  = 1'b0;
        if (clear) begin
            count_d = W'(TIMEOUT_CYC);
        end else if (enable) begin
            if (count_q <= W'(1)) begin
                expire  = 1'b1;
                count_d = W'(TIMEOUT_CYC);
            end else begin
                count_d = count_q - W'(1);
            end
        end
    end

    // Counter register
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_packet.sv
// Packet decoder behind the 16-bit UART receiver: header / payload / checksum.
// Optional statistics counters are enabled with the UART_PKT_STATS_EN macro.
module uart_rx_packet
    import uart_pkt_pkg::*;
#(
    parameter logic [7:0]  SYNC        = PKT_SYNC,
    parameter int unsigned MAX_LEN     = 16,
    parameter int unsigned TIMEOUT_CYC = 112500
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] rx_word,
    input  logic        rx_available,
    output logic [15:0] pkt_data,
    output logic        pkt_valid,
    output logic        pkt_sop,
    output logic        pkt_eop,
    output logic [7:0]  pkt_len,
    output logic        pkt_done,
    output logic [1:0]  pkt_err
`ifdef UART_PKT_STATS_EN
    ,
    output logic [15:0] pkt_count,
    output logic [7:0]  err_count
`endif
);

    state_t      state_q, state_d;
    logic [15:0] sum_q, sum_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  len_q, len_d;
    logic [15:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        sop_q, sop_d;
    logic        eop_q, eop_d;
    logic        done_q, done_d;
    pkt_err_t    err_q, err_d;

    logic sync_ok;
    logic len_ok;
    logic last_word;
    logic to_clear;
    logic to_enable;
    logic to_expire;

    assign sync_ok   = (rx_word[15:8] == SYNC);
    assign len_ok    = (rx_word[7:0] != 8'd0) && (rx_word[7:0] <= 8'(MAX_LEN));
    assign last_word = (cnt_q == len_q - 8'd1);

    // Timer runs only while a packet is open; any received word restarts it
    assign to_clear  = rx_available || (state_q == IDLE);
    assign to_enable = !rx_available && (state_q != IDLE);

    uart_pkt_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clock (clock),
        .reset (reset),
        .clear (to_clear),
        .enable(to_enable),
        .expire(to_expire)
    );

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            sum_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rx_available && sync_ok && len_ok) begin
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (rx_available) begin
                    if (last_word) begin
                        state_d = CHECK;
                    end
                end else if (to_expire) begin
                    state_d = IDLE;
                end
            end
            CHECK: begin
                if (rx_available || to_expire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and strobe generation
    always_comb begin
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        data_d  = data_q;
        valid_d = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        done_d  = 1'b0;
        err_d   = ERR_NONE;
        case (state_q)
            IDLE: begin
                if (rx_available && sync_ok) begin
                    len_d = rx_word[7:0];
                    if (len_ok) begin
                        sum_d = rx_word;
                        cnt_d = '0;
                    end else begin
                        done_d = 1'b1;
                        err_d  = ERR_LEN;
                    end
                end
            end
            PAYLOAD: begin
                if (rx_available) begin
                    data_d  = rx_word;
                    valid_d = 1'b1;
                    sop_d   = (cnt_q == 8'd0);
                    eop_d   = last_word;
                    sum_d   = sum_q + rx_word;
                    cnt_d   = cnt_q + 8'd1;
                end else if (to_expire) begin
                    done_d = 1'b1;
                    err_d  = ERR_TIMEOUT;
                end
            end
            CHECK: begin
                if (rx_available) begin
                    done_d = 1'b1;
                    err_d  = (rx_word == sum_q) ? ERR_NONE : ERR_SUM;
                end else if (to_expire) begin
                    done_d = 1'b1;
                    err_d  = ERR_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    assign pkt_data  = data_q;
    assign pkt_valid = valid_q;
    assign pkt_sop   = sop_q;
    assign pkt_eop   = eop_q;
    assign pkt_len   = len_q;
    assign pkt_done  = done_q;
    assign pkt_err   = err_q;

`ifdef UART_PKT_STATS_EN
    logic [15:0] pcount_q, pcount_d;
    logic [7:0]  ecount_q, ecount_d;

    // Good packets wrap, errors saturate; both follow the pkt_done being issued
    always_comb begin
        pcount_d = pcount_q;
        ecount_d = ecount_q;
        if (done_d) begin
            if (err_d == ERR_NONE) begin
                pcount_d = pcount_q + 16'd1;
            end else if (ecount_q != 8'hFF) begin
                ecount_d = ecount_q + 8'd1;
            end
        end
    end

    // Statistics registers
    always_ff @(posedge clock) begin
        if (reset) begin
            pcount_q <= '0;
            ecount_q <= '0;
        end else begin
            pcount_q <= pcount_d;
            ecount_q <= ecount_d;
        end
    end

    assign pkt_count = pcount_q;
    assign err_count = ecount_q;
`else
    // No statistics counters in this build
`endif

endmodule

// File: tb/tb_uart_rx_packet.sv
// Directed self-checking bench for uart_rx_packet (short timeout for speed).
module tb_uart_rx_packet;

    localparam int unsigned TO = 20;

    logic        clock;
    logic        reset;
    logic [15:0] rx_word;
    logic        rx_available;
    logic [15:0] pkt_data;
    logic        pkt_valid;
    logic        pkt_sop;
    logic        pkt_eop;
    logic [7:0]  pkt_len;
    logic        pkt_done;
    logic [1:0]  pkt_err;
`ifdef UART_PKT_STATS_EN
    logic [15:0] pkt_count;
    logic [7:0]  err_count;
`endif

    int checks = 0;
    int passed = 0;

    uart_rx_packet #(
        .MAX_LEN    (16),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rx_word     (rx_word),
        .rx_available(rx_available),
        .pkt_data    (pkt_data),
        .pkt_valid   (pkt_valid),
        .pkt_sop     (pkt_sop),
        .pkt_eop     (pkt_eop),
        .pkt_len     (pkt_len),
        .pkt_done    (pkt_done),
`ifdef UART_PKT_STATS_EN
        .pkt_err     (pkt_err),
        .pkt_count   (pkt_count),
        .err_count   (err_count)
`else
        .pkt_err     (pkt_err)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Present one word for one cycle; returns 1 time unit after the capturing edge
    task automatic send(input logic [15:0] w);
        @(negedge clock);
        rx_word      = w;
        rx_available = 1'b1;
        @(posedge clock);
        #1;
        rx_available = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk_strobes(input string tag, input logic v, input logic s,
                               input logic e, input logic d);
        chk({tag, "_valid"}, {31'd0, pkt_valid}, {31'd0, v});
        chk({tag, "_sop"},   {31'd0, pkt_sop},   {31'd0, s});
        chk({tag, "_eop"},   {31'd0, pkt_eop},   {31'd0, e});
        chk({tag, "_done"},  {31'd0, pkt_done},  {31'd0, d});
    endtask

    initial begin
        reset        = 1'b1;
        rx_word      = '0;
        rx_available = 1'b0;
        idle_cycles(3);
        chk_strobes("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_len",  {24'd0, pkt_len},  32'd0);
        chk("rst_data", {16'd0, pkt_data}, 32'd0);
        chk("rst_err",  {30'd0, pkt_err},  32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Good packet
        send(16'hA502);
        chk_strobes("g_hdr", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("g_len", {24'd0, pkt_len}, 32'd2);
        send(16'h1234);
        chk_strobes("g_w0", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("g_w0_data", {16'd0, pkt_data}, 32'h1234);
        send(16'h0001);
        chk_strobes("g_w1", 1'b1, 1'b0, 1'b1, 1'b0);
        chk("g_w1_data", {16'd0, pkt_data}, 32'h0001);
        send(16'hB737);
        chk_strobes("g_sum", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("g_err", {30'd0, pkt_err}, 32'd0);
        chk("g_len_hold", {24'd0, pkt_len}, 32'd2);
        idle_cycles(1);
        chk("g_done_pulse", {31'd0, pkt_done}, 32'd0);

        // Bad checksum
        send(16'hA502);
        send(16'h1234);
        chk_strobes("b_w0", 1'b1, 1'b1, 1'b0, 1'b0);
        send(16'h0001);
        chk_strobes("b_w1", 1'b1, 1'b0, 1'b1, 1'b0);
        send(16'h0000);
        chk("b_done", {31'd0, pkt_done}, 32'd1);
        chk("b_err",  {30'd0, pkt_err},  32'd1);

        // Length bounds, back to back (second proves the first stayed IDLE)
        send(16'hA500);
        chk("l0_done", {31'd0, pkt_done}, 32'd1);
        chk("l0_err",  {30'd0, pkt_err},  32'd2);
        chk("l0_len",  {24'd0, pkt_len},  32'd0);
        send(16'hA511);
        chk("l17_done", {31'd0, pkt_done}, 32'd1);
        chk("l17_err",  {30'd0, pkt_err},  32'd2);
        chk("l17_len",  {24'd0, pkt_len},  32'h11);
        send(16'hA510);
        chk("l16_hdr_done", {31'd0, pkt_done}, 32'd0);
        for (int i = 1; i <= 16; i++) begin
            send(16'(i));
            chk("l16_valid", {31'd0, pkt_valid}, 32'd1);
            chk("l16_sop", {31'd0, pkt_sop}, {31'd0, (i == 1)});
            chk("l16_eop", {31'd0, pkt_eop}, {31'd0, (i == 16)});
        end
        send(16'hA598);
        chk("l16_done", {31'd0, pkt_done}, 32'd1);
        chk("l16_err",  {30'd0, pkt_err},  32'd0);

        // Sync filter then wrapping checksum with LEN=1
        send(16'h5A03);
        chk_strobes("sync", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sync_len", {24'd0, pkt_len}, 32'h10);
        send(16'hA501);
        send(16'hFFFF);
        chk_strobes("w_w0", 1'b1, 1'b1, 1'b1, 1'b0);
        send(16'hA500);
        chk("w_done", {31'd0, pkt_done}, 32'd1);
        chk("w_err",  {30'd0, pkt_err},  32'd0);

        // Timeout after TO silent cycles in PAYLOAD
        send(16'hA503);
        send(16'h0001);
        idle_cycles(TO - 1);
        chk("to_early", {31'd0, pkt_done}, 32'd0);
        idle_cycles(1);
        chk("to_done", {31'd0, pkt_done}, 32'd1);
        chk("to_err",  {30'd0, pkt_err},  32'd3);

        // Word landing on the limit cycle wins
        send(16'hA503);
        send(16'h0001);
        idle_cycles(TO - 1);
        send(16'h0002);
        chk("lim_valid", {31'd0, pkt_valid}, 32'd1);
        chk("lim_done",  {31'd0, pkt_done},  32'd0);
        chk("lim_data",  {16'd0, pkt_data},  32'h0002);
        send(16'h0003);
        chk("lim_eop", {31'd0, pkt_eop}, 32'd1);
        send(16'hA509);
        chk("lim_sum_done", {31'd0, pkt_done}, 32'd1);
        chk("lim_sum_err",  {30'd0, pkt_err},  32'd0);

        // Reset mid-packet
        send(16'hA503);
        send(16'h0001);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk_strobes("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid_rst_len",  {24'd0, pkt_len},  32'd0);
        chk("mid_rst_data", {16'd0, pkt_data}, 32'd0);
`ifdef UART_PKT_STATS_EN
        chk("mid_rst_pcount", {16'd0, pkt_count}, 32'd0);
        chk("mid_rst_ecount", {24'd0, err_count}, 32'd0);
`endif
        @(negedge clock);
        reset = 1'b0;
        idle_cycles(1);
        chk("post_rst_done", {31'd0, pkt_done}, 32'd0);
        send(16'hA502);
        send(16'h1234);
        chk_strobes("pr_w0", 1'b1, 1'b1, 1'b0, 1'b0);
        send(16'h0001);
        chk_strobes("pr_w1", 1'b1, 1'b0, 1'b1, 1'b0);
        send(16'hB737);
        chk("pr_done", {31'd0, pkt_done}, 32'd1);
        chk("pr_err",  {30'd0, pkt_err},  32'd0);
`ifdef UART_PKT_STATS_EN
        send(16'hA500);
        chk("st_pcount", {16'd0, pkt_count}, 32'd1);
        chk("st_ecount", {24'd0, err_count}, 32'd1);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
